// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
// Adds two WIDTH*CHUNKS-bit operands one WIDTH-bit chunk per cycle, LSB
// chunk first. The chunk carry is held in a register between cycles. Operands
// enter through a valid/ready handshake, and sum/carry leave through another.
// Optional feature macro: SIGNED_OVF_EN adds an 'ovf' output. It flags
// two's-complement overflow of the full-width add.
module multiword_add_sequencer #(
  parameter int WIDTH  = 8,
  parameter int CHUNKS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH*CHUNKS-1:0]   A,
  input  logic [WIDTH*CHUNKS-1:0]   B,
  input  logic                      Cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH*CHUNKS-1:0]   S,
  output logic                      Cout,
`ifdef SIGNED_OVF_EN
  output logic                      ovf,
`endif
  output logic                      busy
);

  localparam int N  = WIDTH * CHUNKS;
  localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic             carry_reg;
  logic [N-1:0]     a_reg;
  logic [N-1:0]     b_reg;
  logic [N-1:0]     s_reg;
  logic [WIDTH-1:0] a_chunk;
  logic [WIDTH-1:0] b_chunk;
  logic [WIDTH:0]   chunk_sum;
  logic             last_chunk;

  assign in_ready   = (state == ST_IDLE);
  assign out_valid  = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);
  assign S          = s_reg;
  assign Cout       = carry_reg;
  assign last_chunk = (idx == IW'(CHUNKS - 1));

  // Select the operand chunks addressed by idx and add them with the running carry
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < CHUNKS; i++) begin
      if (idx == IW'(i)) begin
        a_chunk = a_reg[i*WIDTH +: WIDTH];
        b_chunk = b_reg[i*WIDTH +: WIDTH];
      end
    end
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{WIDTH{1'b0}}, carry_reg};
  end

  // Handshake FSM, operand capture and chunk-serial sum accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg     <= A;
            b_reg     <= B;
            carry_reg <= Cin;
            idx       <= '0;
            s_reg     <= '0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < CHUNKS; i++) begin
            if (idx == IW'(i)) begin
              s_reg[i*WIDTH +: WIDTH] <= chunk_sum[WIDTH-1:0];
            end
          end
          carry_reg <= chunk_sum[WIDTH];
          if (last_chunk) begin
            state <= ST_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SIGNED_OVF_EN
  // Overflow is the carry into the MSB XOR the carry out of it, taken on the top chunk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (state == ST_IDLE && in_valid) begin
      ovf <= 1'b0;
    end else if (state == ST_RUN && last_chunk) begin
      ovf <= (a_chunk[WIDTH-1] ^ b_chunk[WIDTH-1] ^ chunk_sum[WIDTH-1]) ^ chunk_sum[WIDTH];
    end
  end
`endif

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb_multiword_add_sequencer
// Directed-vector bench for multiword_add_sequencer (WIDTH=8, CHUNKS=4).
// Extra ovf vectors are included when SIGNED_OVF_EN is defined.
module tb_multiword_add_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] S;
  logic        Cout;
  logic        busy;
`ifdef SIGNED_OVF_EN
  logic        ovf;
`endif

  int total = 0;
  int bad   = 0;

  multiword_add_sequencer #(.WIDTH(8), .CHUNKS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout),
`ifdef SIGNED_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  // Free-running clock with a 10-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when observed and expected differ
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Offer one operand set, check the latency and result, and optionally hold
  // back the consumer for some cycles while poking in_valid
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic cin,
                               input logic [31:0] expS, input logic expC, input logic expOvf,
                               input int holdCycles);
    int cycles;
    @(negedge clk);
    A = a; B = b; Cin = cin; in_valid = 1'b1; out_ready = 1'b0;
    checkOutput("in_ready_idle", 64'(in_ready), 64'(1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = ~a; B = ~b; Cin = ~cin;
    checkOutput("busy_run", 64'(busy), 64'(1'b1));
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput("latency", 64'(cycles), 64'(4));
    checkOutput("sum", 64'(S), 64'(expS));
    checkOutput("cout", 64'(Cout), 64'(expC));
    checkOutput("in_ready_done", 64'(in_ready), 64'(1'b0));
`ifdef SIGNED_OVF_EN
    checkOutput("ovf", 64'(ovf), 64'(expOvf));
`else
    if (expOvf === 1'bx) $display("[TB] note: unexpected unknown ovf expectation");
`endif
    for (int i = 0; i < holdCycles; i++) begin
      in_valid = 1'b1;
      A = 32'hDEADBEEF; B = 32'h01234567; Cin = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("hold_valid", 64'(out_valid), 64'(1'b1));
      checkOutput("hold_in_ready", 64'(in_ready), 64'(1'b0));
      checkOutput("hold_sum", 64'(S), 64'(expS));
      checkOutput("hold_cout", 64'(Cout), 64'(expC));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("release_valid", 64'(out_valid), 64'(1'b0));
    checkOutput("release_in_ready", 64'(in_ready), 64'(1'b1));
    checkOutput("release_sum_kept", 64'(S), 64'(expS));
  endtask

  // Main directed sequence
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0;
    #12;
    checkOutput("rst_out_valid", 64'(out_valid), 64'(1'b0));
    checkOutput("rst_in_ready", 64'(in_ready), 64'(1'b1));
    checkOutput("rst_busy", 64'(busy), 64'(1'b0));
    checkOutput("rst_sum", 64'(S), 64'(0));
    checkOutput("rst_cout", 64'(Cout), 64'(0));
`ifdef SIGNED_OVF_EN
    checkOutput("rst_ovf", 64'(ovf), 64'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 0);
    applyStimulus(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 0);
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 0);
    applyStimulus(32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0, 0);
    applyStimulus(32'h80000000, 32'h80000001, 1'b0, 32'h00000001, 1'b1, 1'b1, 5);

    // Reset in the middle of RUN while idx is 2
    @(negedge clk);
    A = 32'h01010101; B = 32'h01010101; Cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("mid_run_partial", 64'(S), 64'(32'h00000202));
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'(1'b0));
    checkOutput("midrst_busy", 64'(busy), 64'(1'b0));
    checkOutput("midrst_sum", 64'(S), 64'(0));
    checkOutput("midrst_cout", 64'(Cout), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32'd5, 32'd7, 1'b0, 32'd12, 1'b0, 1'b0, 0);

`ifdef SIGNED_OVF_EN
    applyStimulus(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 0);
    applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
